ibex_data_sram_adapter: RTL and testbench

- Sits directly downstream of the core data memory interface (req/gnt/rvalid, with integrity bits).
- Terminates core data transactions on a single-port SRAM with fixed read latency.
- Generates read-data integrity, checks write-data integrity and returns bus errors for out-of-range accesses.
- Keeps responses in order through a latency-matched response pipeline.

---
 rtl/ibex_sram_adapter_pkg.sv | 13 +
 rtl/ibex_resp_pipe.sv | 31 +++
 rtl/ibex_secded_inv_39_32_enc.sv | 19 +
 rtl/ibex_data_sram_adapter.sv | 94 +++++++++
 tb/tb_ibex_data_sram_adapter.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ibex_sram_adapter_pkg.sv
// Shared types and constants for the core data-port SRAM adapter.
// Response stages carry valid/err plus a read flag to select returned data.
package ibex_sram_adapter_pkg;

   localparam logic [6:0] IntgZero = 7'h2A;

   typedef struct packed {
      logic valid;
      logic err;
      logic rd;
   } resp_stage_t;

endpackage

// File: rtl/ibex_resp_pipe.sv
// Latency-deep response shift register; never stalls since the core
// always accepts rvalid.
module ibex_resp_pipe
   import ibex_sram_adapter_pkg::*;
#(
   parameter int unsigned Latency = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  resp_stage_t resp_i,
   output resp_stage_t resp_o
);

   resp_stage_t pipe_q [Latency];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < Latency; i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         pipe_q[0] <= resp_i;
         for (int i = 1; i < Latency; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   assign resp_o = pipe_q[Latency-1];

endmodule

// File: rtl/ibex_secded_inv_39_32_enc.sv
// Inverted Hsiao (39,32) encoder: returns the seven check bits only.
// Inversion makes all-zero data encode to a non-zero pattern.
module ibex_secded_inv_39_32_enc (
   input  logic [31:0] data_i,
   output logic [6:0]  intg_o
);

   always_comb begin
      intg_o[0] = ^(data_i & 32'h2606_BD25);
      intg_o[1] = ^(data_i & 32'hDEBA_8050);
      intg_o[2] = ^(data_i & 32'h413D_89AA);
      intg_o[3] = ^(data_i & 32'h3123_4ED1);
      intg_o[4] = ^(data_i & 32'hC2C1_323B);
      intg_o[5] = ^(data_i & 32'h2DCC_624C);
      intg_o[6] = ^(data_i & 32'h9850_5586);
      intg_o    = intg_o ^ 7'h2A;
   end

endmodule

// File: rtl/ibex_data_sram_adapter.sv
// Terminates core data-port transactions on a fixed-latency single-port
// SRAM, with integrity check/generation and in-order range errors.
module ibex_data_sram_adapter
   import ibex_sram_adapter_pkg::*;
#(
   parameter logic [31:0] BaseAddr = 32'h0010_0000,
   parameter int unsigned MemSize  = 65536,
   parameter int unsigned Latency  = 1,
   parameter int unsigned MemAw    = $clog2(MemSize / 4)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             data_req_i,
   output logic             data_gnt_o,
   output logic             data_rvalid_o,
   input  logic             data_we_i,
   input  logic [3:0]       data_be_i,
   input  logic [31:0]      data_addr_i,
   input  logic [31:0]      data_wdata_i,
   input  logic [6:0]       data_wdata_intg_i,
   output logic [31:0]      data_rdata_o,
   output logic [6:0]       data_rdata_intg_o,
   output logic             data_err_o,
   output logic             mem_req_o,
   input  logic             mem_gnt_i,
   output logic             mem_we_o,
   output logic [3:0]       mem_be_o,
   output logic [MemAw-1:0] mem_addr_o,
   output logic [31:0]      mem_wdata_o,
   input  logic [31:0]      mem_rdata_i,
   output logic             alert_intg_o
);

   logic [31:0] offset;
   logic        in_range;
   logic [6:0]  wr_intg;
   logic [6:0]  rd_intg;
   logic        wr_intg_err;
   logic        rd_ok;
   resp_stage_t resp_in;
   resp_stage_t resp_out;

   // Subtraction wraps addresses below the window to large values.
   assign offset   = data_addr_i - BaseAddr;
   assign in_range = offset < MemSize;

   ibex_secded_inv_39_32_enc u_wr_enc (
      .data_i (data_wdata_i),
      .intg_o (wr_intg)
   );

   assign wr_intg_err = data_req_i && data_we_i && in_range &&
                        (wr_intg != data_wdata_intg_i);

   // Errored requests are granted locally without touching the SRAM.
   assign data_gnt_o = data_req_i &&
                       (!in_range || wr_intg_err || mem_gnt_i);
   assign mem_req_o  = data_req_i && in_range && !wr_intg_err;

   assign mem_we_o     = data_we_i;
   assign mem_be_o     = data_be_i;
   assign mem_wdata_o  = data_wdata_i;
   assign mem_addr_o   = offset[MemAw+1:2];
   assign alert_intg_o = wr_intg_err;

   always_comb begin
      resp_in       = '0;
      resp_in.valid = data_gnt_o;
      resp_in.err   = !in_range || wr_intg_err;
      resp_in.rd    = !data_we_i;
   end

   ibex_resp_pipe #(
      .Latency (Latency)
   ) u_resp_pipe (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .resp_i (resp_in),
      .resp_o (resp_out)
   );

   ibex_secded_inv_39_32_enc u_rd_enc (
      .data_i (mem_rdata_i),
      .intg_o (rd_intg)
   );

   assign rd_ok = resp_out.valid && !resp_out.err && resp_out.rd;

   assign data_rvalid_o     = resp_out.valid;
   assign data_err_o        = resp_out.valid && resp_out.err;
   assign data_rdata_o      = rd_ok ? mem_rdata_i : 32'h0;
   assign data_rdata_intg_o = rd_ok ? rd_intg : IntgZero;

endmodule

// File: tb/tb_ibex_data_sram_adapter.sv
// Bench for the data SRAM adapter: Latency=1 and Latency=3 instances
// share stimulus and are checked against a slot-scheduled reference.
module tb_ibex_data_sram_adapter;

   localparam logic [31:0] BASE = 32'h0010_0000;
   localparam int unsigned SIZE = 65536;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        req = 0, we = 0, mgnt = 0;
   logic [3:0]  be = 0;
   logic [31:0] addr = 0, wdata = 0, mrdata = 0;
   logic [6:0]  wintg = 0;

   logic        gnt [2], rv [2], err [2], mreq [2], mwe [2], alert [2];
   logic [31:0] rdata [2], mwdata [2];
   logic [6:0]  rintg [2];
   logic [3:0]  mbe [2];
   logic [13:0] maddr [2];

   ibex_data_sram_adapter #(.BaseAddr(BASE), .MemSize(SIZE), .Latency(1)) u_l1 (
      .clk_i(clk), .rst_i(rst), .data_req_i(req), .data_gnt_o(gnt[0]),
      .data_rvalid_o(rv[0]), .data_we_i(we), .data_be_i(be),
      .data_addr_i(addr), .data_wdata_i(wdata), .data_wdata_intg_i(wintg),
      .data_rdata_o(rdata[0]), .data_rdata_intg_o(rintg[0]),
      .data_err_o(err[0]), .mem_req_o(mreq[0]), .mem_gnt_i(mgnt),
      .mem_we_o(mwe[0]), .mem_be_o(mbe[0]), .mem_addr_o(maddr[0]),
      .mem_wdata_o(mwdata[0]), .mem_rdata_i(mrdata), .alert_intg_o(alert[0])
   );

   ibex_data_sram_adapter #(.BaseAddr(BASE), .MemSize(SIZE), .Latency(3)) u_l3 (
      .clk_i(clk), .rst_i(rst), .data_req_i(req), .data_gnt_o(gnt[1]),
      .data_rvalid_o(rv[1]), .data_we_i(we), .data_be_i(be),
      .data_addr_i(addr), .data_wdata_i(wdata), .data_wdata_intg_i(wintg),
      .data_rdata_o(rdata[1]), .data_rdata_intg_o(rintg[1]),
      .data_err_o(err[1]), .mem_req_o(mreq[1]), .mem_gnt_i(mgnt),
      .mem_we_o(mwe[1]), .mem_be_o(mbe[1]), .mem_addr_o(maddr[1]),
      .mem_wdata_o(mwdata[1]), .mem_rdata_i(mrdata), .alert_intg_o(alert[1])
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Expected response per instance, indexed by the cycle it must appear in.
   bit ev [2][64];
   bit ee [2][64];
   bit er [2][64];

   typedef struct {
      logic        rq, w;
      logic [3:0]  b;
      logic [31:0] a, wd;
      logic [6:0]  wi;
      logic        mg;
      logic [31:0] md;
      logic        e_gnt, e_mreq, e_alert;
   } vec_t;

   function automatic logic [6:0] enc(input logic [31:0] d);
      logic [31:0] m [7];
      logic [6:0]  c;
      m = '{32'h2606BD25, 32'hDEBA8050, 32'h413D89AA, 32'h31234ED1,
            32'hC2C1323B, 32'h2DCC624C, 32'h98505586};
      for (int j = 0; j < 7; j++) begin
         c[j] = 1'b0;
         for (int i = 0; i < 32; i++) if (m[j][i]) c[j] ^= d[i];
      end
      return c ^ 7'h2A;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic clear_model();
      for (int k = 0; k < 2; k++)
         for (int s = 0; s < 64; s++) begin
            ev[k][s] = 0; ee[k][s] = 0; er[k][s] = 0;
         end
   endtask

   task automatic step(input logic rq, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [6:0] wi, input logic mg,
                       input logic [31:0] md);
      logic [31:0] off, xd;
      logic inr, werr, g, mr, ok;
      int lat, s, d;
      @(posedge clk);
      cyc++;
      #1;
      req = rq; we = w; be = b; addr = a; wdata = wd; wintg = wi;
      mgnt = mg; mrdata = md;
      #1;
      off  = a - BASE;
      inr  = off < SIZE;
      werr = rq && w && inr && (enc(wd) != wi);
      g    = rq && (!inr || werr || mg);
      mr   = rq && inr && !werr;
      for (int k = 0; k < 2; k++) begin
         lat = (k == 0) ? 1 : 3;
         s   = cyc % 64;
         chk("gnt", 32'(gnt[k]), 32'(g));
         chk("mem_req", 32'(mreq[k]), 32'(mr));
         chk("alert", 32'(alert[k]), 32'(werr));
         chk("mem_addr", 32'(maddr[k]), 32'(off[15:2]));
         chk("mem_we", 32'(mwe[k]), 32'(w));
         chk("mem_be", 32'(mbe[k]), 32'(b));
         chk("mem_wdata", mwdata[k], wd);
         ok = ev[k][s] && !ee[k][s] && er[k][s];
         xd = ok ? md : 32'h0;
         chk(k ? "rvalid_l3" : "rvalid_l1", 32'(rv[k]), 32'(ev[k][s]));
         chk(k ? "err_l3" : "err_l1", 32'(err[k]), 32'(ev[k][s] && ee[k][s]));
         chk(k ? "rdata_l3" : "rdata_l1", rdata[k], xd);
         chk(k ? "rintg_l3" : "rintg_l1", 32'(rintg[k]),
             32'(ok ? enc(md) : 7'h2A));
         ev[k][s] = 0;
         if (g) begin
            d = (cyc + lat) % 64;
            ev[k][d] = 1;
            ee[k][d] = !inr || werr;
            er[k][d] = !w;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         step(0, 0, 4'h0, 32'h0, 32'h0, 7'h0, $urandom % 2, $urandom);
   endtask

   task automatic check_reset_outputs();
      for (int k = 0; k < 2; k++) begin
         chk("rst_rvalid", 32'(rv[k]), 32'h0);
         chk("rst_err", 32'(err[k]), 32'h0);
         chk("rst_rdata", rdata[k], 32'h0);
         chk("rst_rintg", 32'(rintg[k]), 32'h2A);
         chk("rst_gnt", 32'(gnt[k]), 32'h0);
         chk("rst_mem_req", 32'(mreq[k]), 32'h0);
         chk("rst_alert", 32'(alert[k]), 32'h0);
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      cyc++;
      #1;
      rst = 1; req = 0; we = 0; be = 0; addr = 0; wdata = 0;
      wintg = 0; mgnt = 0; mrdata = 0;
      #1;
      check_reset_outputs();
      clear_model();
      repeat (2) begin
         @(posedge clk);
         cyc++;
      end
      #1 rst = 0;
   endtask

   vec_t tbl [16];
   int   nrv;

   initial begin
      clear_model();
      #2;
      check_reset_outputs();
      repeat (2) @(posedge clk);
      #1 rst = 0;

      tbl[0]  = '{1, 0, 4'hF, 32'h0010_0010, 0, 0, 1, 0, 1, 1, 0};
      tbl[1]  = '{0, 0, 4'h0, 0, 0, 0, 0, 32'hDEAD_BEEF, 0, 0, 0};
      tbl[2]  = '{1, 0, 4'hF, 32'h0011_0000, 0, 0, 0, 0, 1, 0, 0};
      tbl[3]  = '{0, 0, 4'h0, 0, 0, 0, 0, 32'h5555_AAAA, 0, 0, 0};
      tbl[4]  = '{1, 1, 4'hF, 32'h0010_0020, 32'h1234_5678,
                  enc(32'h1234_5678) ^ 7'h01, 1, 0, 1, 0, 1};
      tbl[5]  = '{0, 0, 4'h0, 0, 0, 0, 1, 32'h0, 0, 0, 0};
      tbl[6]  = '{1, 0, 4'hF, 32'h0010_FFFC, 0, 0, 1, 32'h1, 1, 1, 0};
      tbl[7]  = '{1, 0, 4'hF, 32'h000F_FFFC, 0, 0, 1, 32'h2, 1, 0, 0};
      tbl[8]  = '{1, 1, 4'h0, 32'h0010_0040, 32'hA5A5_A5A5,
                  enc(32'hA5A5_A5A5), 1, 32'h3, 1, 1, 0};
      tbl[9]  = '{1, 0, 4'hF, 32'h0010_0100, 0, 0, 1, 32'h4, 1, 1, 0};
      tbl[10] = '{1, 0, 4'hF, 32'h0020_0000, 0, 0, 1, 32'h5, 1, 0, 0};
      tbl[11] = '{1, 1, 4'h3, 32'h0010_0104, 32'hCAFE_F00D,
                  enc(32'hCAFE_F00D), 1, 32'h6, 1, 1, 0};
      tbl[12] = '{1, 0, 4'hF, 32'h0010_0108, 0, 0, 1, 32'h7, 1, 1, 0};
      tbl[13] = '{0, 0, 4'h0, 0, 0, 0, 0, 32'h0BAD_F00D, 0, 0, 0};
      tbl[14] = '{0, 0, 4'h0, 0, 0, 0, 0, 32'h1357_9BDF, 0, 0, 0};
      tbl[15] = '{0, 0, 4'h0, 0, 0, 0, 0, 32'h2468_ACE0, 0, 0, 0};

      for (int i = 0; i < 16; i++) begin
         step(tbl[i].rq, tbl[i].w, tbl[i].b, tbl[i].a, tbl[i].wd,
              tbl[i].wi, tbl[i].mg, tbl[i].md);
         chk("tbl_gnt", 32'(gnt[0]), 32'(tbl[i].e_gnt));
         chk("tbl_mem_req", 32'(mreq[0]), 32'(tbl[i].e_mreq));
         chk("tbl_alert", 32'(alert[0]), 32'(tbl[i].e_alert));
         if (i == 0) chk("tbl_mem_addr", 32'(maddr[0]), 32'h4);
         if (i == 1) chk("tbl_rdata_beef", rdata[0], 32'hDEAD_BEEF);
         if (i == 1) chk("tbl_rintg_beef", 32'(rintg[0]),
                         32'(enc(32'hDEAD_BEEF)));
      end

      // Grant stall: three cycles of mem_gnt_i low, then high.
      nrv = 0;
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 4'hF, 32'h0010_0200, 0, 0, (i == 3), $urandom);
         chk("stall_gnt", 32'(gnt[0]), 32'(i == 3));
      end
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 4'h0, 0, 0, 0, 1, $urandom);
         nrv += int'(rv[0]);
      end
      chk("stall_one_rvalid", 32'(nrv), 32'h1);

      // Reset with two responses in flight on the Latency=3 instance.
      step(1, 0, 4'hF, 32'h0010_0300, 0, 0, 1, 0);
      step(1, 0, 4'hF, 32'h0010_0304, 0, 0, 1, 0);
      do_reset();
      nrv = 0;
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 4'h0, 0, 0, 0, 1, $urandom);
         nrv += int'(rv[0]) + int'(rv[1]);
      end
      chk("post_rst_no_rvalid", 32'(nrv), 32'h0);

      // Random traffic across in-range, edges and out-of-range.
      for (int i = 0; i < 400; i++) begin
         logic [31:0] a, wd;
         logic [6:0]  wi;
         logic        w;
         case ($urandom % 6)
            0:       a = BASE + SIZE - 4 + ($urandom % 8);
            1:       a = BASE - 1 - ($urandom % 16);
            2:       a = $urandom;
            default: a = BASE + ($urandom % SIZE);
         endcase
         w  = $urandom % 2;
         wd = $urandom;
         wi = (($urandom % 8) == 0) ? enc(wd) ^ 7'(1 << ($urandom % 7))
                                    : enc(wd);
         step(($urandom % 4) != 0, w, 4'($urandom), a, wd, wi,
              ($urandom % 3) != 0, $urandom);
      end
      idle(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
